// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/issue sequencer with program counter and halt/illegal detection
module instr_sequencer #(
    parameter int ADDR_W = 8,
    parameter int IMM_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    output logic                imem_rd,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [6+IMM_W-1:0]  imem_rdata,
    output logic [5:0]          opcode,
    output logic [IMM_W-1:0]    imm,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [ADDR_W-1:0]   pc,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int IW = 6 + IMM_W;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [IW-1:0]     ir_q, ir_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [5:0]        rd_op;

    assign rd_op = imem_rdata[IW-1 -: 6];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        done_d  = done_q;
        error_d = error_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pc_d    = start_addr;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                ir_d = imem_rdata;
                // Only opcodes 0..7 are implemented by the controller.
                if (rd_op[5:3] == 3'b000) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    error_d = (rd_op != OP_HALT);
                end
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign instr_valid = (state_q == S_ISSUE);
    assign opcode      = instr_valid ? ir_q[IW-1 -: 6] : 6'b000000;
    assign imm         = instr_valid ? ir_q[IMM_W-1:0] : '0;
    assign imem_rd     = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign busy        = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_ISSUE);
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  start_addr;
    logic        imem_rd;
    logic [7:0]  imem_addr;
    logic [13:0] imem_rdata = '0;
    logic [5:0]  opcode;
    logic [7:0]  imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  pc;
    logic        busy;
    logic        done;
    logic        error;

    logic [13:0] mem [256];
    int n_checks = 0;
    int n_errors = 0;

    instr_sequencer #(.ADDR_W(8), .IMM_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .opcode(opcode), .imm(imm), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc(pc), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd) imem_rdata <= mem[imem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) mem[i] = 14'h3F00;
    endtask

    task automatic load_basic();
        fill_halt();
        mem[0] = 14'h0105;
        mem[1] = 14'h0203;
        mem[2] = 14'h0300;
        mem[3] = 14'h3F00;
    endtask

    task automatic load_illegal();
        fill_halt();
        mem[0] = 14'h0400;
        mem[1] = 14'h08AA;
    endtask

    task automatic do_start(input logic [7:0] a);
        start = 1'b1;
        start_addr = a;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_timeout: done=%b required 1 within %0d cycles", name, done, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start_addr = '0; instr_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({opcode, imm, instr_valid, imem_rd, imem_addr, pc, busy, done, error} !== '0) begin
            n_errors++;
            $display("FAIL reset_values: op=%h imm=%h v=%b rd=%b addr=%h pc=%h busy=%b done=%b err=%b required all 0",
                     opcode, imm, instr_valid, imem_rd, imem_addr, pc, busy, done, error);
        end
    endtask

    task automatic test_basic();
        logic [5:0] eop [3];
        logic [7:0] eimm [3];
        logic       exp_v;
        int         idx;
        eop[0] = 6'h01; eop[1] = 6'h02; eop[2] = 6'h03;
        eimm[0] = 8'h05; eimm[1] = 8'h03; eimm[2] = 8'h00;
        load_basic();
        instr_ready = 1'b1;
        do_start(8'h00);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            exp_v = (cyc == 3) || (cyc == 6) || (cyc == 9);
            n_checks++;
            if (instr_valid !== exp_v) begin
                n_errors++;
                $display("FAIL basic_valid c%0d: got %b required %b", cyc, instr_valid, exp_v);
            end
            n_checks++;
            if (exp_v) begin
                idx = cyc / 3 - 1;
                if (opcode !== eop[idx] || imm !== eimm[idx]) begin
                    n_errors++;
                    $display("FAIL basic_issue c%0d: got %h/%h required %h/%h", cyc, opcode, imm, eop[idx], eimm[idx]);
                end
            end else if (opcode !== 6'h00 || imm !== 8'h00) begin
                n_errors++;
                $display("FAIL basic_idle_zero c%0d: got %h/%h required 00/00", cyc, opcode, imm);
            end
            if (cyc == 1 || cyc == 10) begin
                n_checks++;
                if (imem_rd !== 1'b1 || imem_addr !== ((cyc == 1) ? 8'h00 : 8'h03)) begin
                    n_errors++;
                    $display("FAIL basic_fetch c%0d: rd=%b addr=%h", cyc, imem_rd, imem_addr);
                end
            end
            if (cyc == 12) begin
                n_checks++;
                if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || pc !== 8'h03) begin
                    n_errors++;
                    $display("FAIL basic_done: done=%b busy=%b err=%b pc=%h required 1/0/0/03", done, busy, error, pc);
                end
            end
            if (cyc < 12) tick();
        end
    endtask

    task automatic test_backpressure();
        int acc;
        acc = 0;
        load_basic();
        instr_ready = 1'b1;
        do_start(8'h00);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            instr_ready = !(cyc >= 3 && cyc <= 6);
            if (cyc >= 3 && cyc <= 7) begin
                n_checks++;
                if (instr_valid !== 1'b1 || opcode !== 6'h01 || imm !== 8'h05 || pc !== 8'h00) begin
                    n_errors++;
                    $display("FAIL bp_hold c%0d: v=%b op=%h imm=%h pc=%h required 1/01/05/00", cyc, instr_valid, opcode, imm, pc);
                end
            end
            if (cyc == 10) begin
                n_checks++;
                if (instr_valid !== 1'b1 || opcode !== 6'h02 || imm !== 8'h03) begin
                    n_errors++;
                    $display("FAIL bp_next c10: v=%b op=%h imm=%h required 1/02/03", instr_valid, opcode, imm);
                end
            end else if (instr_valid && instr_ready) begin
                acc++;
            end
            if (cyc < 10) tick();
        end
        n_checks++;
        if (acc !== 1) begin
            n_errors++;
            $display("FAIL bp_accept_count: got %0d required 1", acc);
        end
        instr_ready = 1'b1;
        wait_done("bp", 30);
    endtask

    task automatic test_illegal();
        int issues;
        int bad;
        issues = 0;
        bad = 0;
        load_illegal();
        instr_ready = 1'b1;
        do_start(8'h00);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (instr_valid) begin
                issues++;
                if (opcode !== 6'h04) bad++;
            end
            if (opcode === 6'h08) bad++;
            tick();
        end
        n_checks++;
        if (issues !== 1 || bad !== 0) begin
            n_errors++;
            $display("FAIL illegal_issue: issues=%0d bad=%0d required 1/0", issues, bad);
        end
        n_checks++;
        if (done !== 1'b1 || error !== 1'b1 || pc !== 8'h01 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL illegal_done: done=%b err=%b pc=%h busy=%b required 1/1/01/0", done, error, pc, busy);
        end
    endtask

    task automatic test_start_after_error();
        do_start(8'h00);
        n_checks++;
        if (done !== 1'b0 || error !== 1'b0 || imem_rd !== 1'b1 || imem_addr !== 8'h00 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL restart_clear: done=%b err=%b rd=%b addr=%h busy=%b required 0/0/1/00/1",
                     done, error, imem_rd, imem_addr, busy);
        end
        tick();
        tick();
        n_checks++;
        if (instr_valid !== 1'b1 || opcode !== 6'h04) begin
            n_errors++;
            $display("FAIL restart_reexec: v=%b op=%h required 1/04", instr_valid, opcode);
        end
        wait_done("restart", 30);
    endtask

    task automatic test_wrap();
        fill_halt();
        mem[255] = 14'h0711;
        mem[0]   = 14'h3F00;
        instr_ready = 1'b1;
        do_start(8'hFF);
        tick();
        tick();
        n_checks++;
        if (instr_valid !== 1'b1 || opcode !== 6'h07 || imm !== 8'h11 || pc !== 8'hFF) begin
            n_errors++;
            $display("FAIL wrap_issue: v=%b op=%h imm=%h pc=%h required 1/07/11/FF", instr_valid, opcode, imm, pc);
        end
        tick();
        n_checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 8'h00) begin
            n_errors++;
            $display("FAIL wrap_fetch: rd=%b addr=%h required 1/00", imem_rd, imem_addr);
        end
        tick();
        tick();
        n_checks++;
        if (done !== 1'b1 || error !== 1'b0 || pc !== 8'h00) begin
            n_errors++;
            $display("FAIL wrap_done: done=%b err=%b pc=%h required 1/0/00", done, error, pc);
        end
    endtask

    task automatic test_start_during_wait();
        load_basic();
        instr_ready = 1'b0;
        do_start(8'h00);
        tick();
        start = 1'b1;
        start_addr = 8'h40;
        tick();
        start = 1'b0;
        n_checks++;
        if (pc !== 8'h00 || instr_valid !== 1'b1 || opcode !== 6'h01) begin
            n_errors++;
            $display("FAIL start_in_wait: pc=%h v=%b op=%h required 00/1/01", pc, instr_valid, opcode);
        end
        instr_ready = 1'b1;
        wait_done("start_wait", 30);
    endtask

    task automatic test_reset_mid_issue();
        int stray;
        stray = 0;
        load_basic();
        instr_ready = 1'b0;
        do_start(8'h00);
        tick();
        tick();
        n_checks++;
        if (instr_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL rmid_pre: v=%b required 1", instr_valid);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if ({opcode, imm, instr_valid, imem_rd, imem_addr, pc, busy, done, error} !== '0) begin
            n_errors++;
            $display("FAIL rmid_values: op=%h imm=%h v=%b rd=%b addr=%h pc=%h busy=%b done=%b err=%b required all 0",
                     opcode, imm, instr_valid, imem_rd, imem_addr, pc, busy, done, error);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (instr_valid || busy) stray++;
        end
        n_checks++;
        if (stray !== 0) begin
            n_errors++;
            $display("FAIL rmid_stray: active cycles=%0d required 0", stray);
        end
    endtask

    initial begin
        fill_halt();
        test_reset();
        test_basic();
        test_backpressure();
        test_illegal();
        test_start_after_error();
        test_wrap();
        test_start_during_wait();
        test_reset_mid_issue();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
